// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M-style multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic op_signed_a(input muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_signed_b(input muldiv_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with FIX-stage sign correction.
// Define MULDIV_SINGLE_CYCLE_MUL_EN for a combinational multiply (IDLE -> FIX -> DONE).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam int unsigned PW    = 2 * XLEN;

    muldiv_state_t   state_q, state_n;
    muldiv_op_t      op_q, op_c;
    logic [XLEN-1:0] hi_q, lo_q, opd_q;
    logic            neg_lo_q, neg_hi_q;
    logic [CNT_W-1:0] cnt_q;

    // Operand decode at the accept edge
    logic            a_neg_c, b_neg_c, accept_c;
    logic            div_zero_c, div_ovf_c, special_c, bypass_c;
    logic [XLEN-1:0] a_mag_c, b_mag_c;

    assign op_c = muldiv_op_t'(op);

    always_comb begin
        a_neg_c    = op_signed_a(op_c) & a[XLEN-1];
        b_neg_c    = op_signed_b(op_c) & b[XLEN-1];
        a_mag_c    = a_neg_c ? (~a + XLEN'(1)) : a;
        b_mag_c    = b_neg_c ? (~b + XLEN'(1)) : b;
        div_zero_c = op_is_div(op_c) && (b == '0);
        div_ovf_c  = (op_c == OP_DIV || op_c == OP_REM)
                     && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        special_c  = div_zero_c | div_ovf_c;
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
        bypass_c   = special_c | ~op_is_div(op_c);
`else
        bypass_c   = special_c;
`endif
        accept_c   = (state_q == ST_IDLE) && start && !kill;
    end

    // Next-state logic; kill from any busy state returns to IDLE
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE: if (start) state_n = bypass_c ? ST_FIX : ST_CALC;
            ST_CALC: if (cnt_q == CNT_W'(XLEN - 1)) state_n = ST_FIX;
            ST_FIX:  state_n = ST_DONE;
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        if (kill) state_n = ST_IDLE;
    end

    // One shift-add or restoring-subtract step per CALC cycle
    logic [XLEN:0]   mul_sum_c, div_shift_c;
    logic [XLEN-1:0] div_diff_c;
    logic            div_ge_c;

    always_comb begin
        mul_sum_c   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        div_shift_c = {hi_q, lo_q[XLEN-1]};
        div_ge_c    = div_shift_c >= {1'b0, opd_q};
        div_diff_c  = XLEN'(div_shift_c - {1'b0, opd_q});
    end

    // Sign correction and result selection in FIX
    logic [PW-1:0]   raw_prod_c, prod_c;
    logic [XLEN-1:0] quo_c, rem_c, fix_c;

    always_comb begin
        raw_prod_c = {hi_q, lo_q};
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
        if (!op_is_div(op_q)) raw_prod_c = PW'(opd_q) * PW'(lo_q);
`endif
        prod_c = neg_lo_q ? (~raw_prod_c + PW'(1)) : raw_prod_c;
        quo_c  = neg_lo_q ? (~lo_q + XLEN'(1)) : lo_q;
        rem_c  = neg_hi_q ? (~hi_q + XLEN'(1)) : hi_q;
        fix_c  = '0;
        case (op_q)
            OP_MUL:                       fix_c = prod_c[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_c = prod_c[PW-1:XLEN];
            OP_DIV, OP_DIVU:              fix_c = quo_c;
            default:                      fix_c = rem_c;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            hi_q     <= '0;
            lo_q     <= '0;
            opd_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            state_q <= state_n;
            busy    <= (state_n != ST_IDLE);
            done    <= (state_q == ST_DONE) && !kill;
            if (accept_c) begin
                op_q     <= op_c;
                cnt_q    <= '0;
                neg_lo_q <= !special_c && (a_neg_c ^ b_neg_c);
                neg_hi_q <= !special_c && a_neg_c;
                opd_q    <= op_is_div(op_c) ? b_mag_c : a_mag_c;
                // Special cases preload the final quotient (lo) and remainder (hi)
                if (div_zero_c) begin
                    hi_q <= a;
                    lo_q <= '1;
                end else if (div_ovf_c) begin
                    hi_q <= '0;
                    lo_q <= a;
                end else begin
                    hi_q <= '0;
                    lo_q <= op_is_div(op_c) ? a_mag_c : b_mag_c;
                end
            end else if (state_q == ST_CALC) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (op_is_div(op_q)) begin
                    hi_q <= div_ge_c ? div_diff_c : div_shift_c[XLEN-1:0];
                    lo_q <= {lo_q[XLEN-2:0], div_ge_c};
                end else begin
                    hi_q <= mul_sum_c[XLEN:1];
                    lo_q <= {mul_sum_c[0], lo_q[XLEN-1:1]};
                end
            end
            if (state_q == ST_FIX && state_n == ST_DONE) result <= fix_c;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed literal cases plus randomized ops against an arithmetic model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int unsigned XLEN = 32;
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    localparam int unsigned MUL_LAT = 2;
`else
    localparam int unsigned MUL_LAT = XLEN + 2;
`endif
    localparam int unsigned DIV_LAT = XLEN + 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [2:0]      op = 3'b000;
    logic [XLEN-1:0] a = '0;
    logic [XLEN-1:0] b = '0;
    logic            kill = 1'b0;
    logic            busy, done;
    logic [XLEN-1:0] result;

    int checks = 0;
    int passes = 0;
    bit cmp_en = 1'b0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference arithmetic, written straight from the RV32M rules
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, ux, uy;
        logic [63:0] p;
        logic        ovf;
        logic [31:0] r;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = longint'({32'b0, x});
        uy  = longint'({32'b0, y});
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        r   = '0;
        case (f)
            3'b000: begin p = 64'(ux * uy); r = p[31:0];  end
            3'b001: begin p = 64'(sx * sy); r = p[63:32]; end
            3'b010: begin p = 64'(sx * uy); r = p[63:32]; end
            3'b011: begin p = 64'(ux * uy); r = p[63:32]; end
            3'b100: r = (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'(sx / sy);
            3'b101: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'b110: r = (y == 0) ? x : ovf ? 32'd0 : 32'(sx % sy);
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    function automatic int unsigned ref_latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 2;
        if (!f[2]) return MUL_LAT;
        return DIV_LAT;
    endfunction

    // Model: edges remaining until done; result appears one edge before done
    int unsigned     left = 0;
    logic            m_busy = 1'b0, m_done = 1'b0;
    logic [31:0]     m_result = '0, m_pending = '0;

    always @(posedge clk) begin : model_b
        int unsigned l;
        logic        d;
        logic [31:0] r, pend;
        l = left; d = 1'b0; r = m_result; pend = m_pending;
        if (reset) begin
            l = 0; r = '0;
        end else if (l != 0) begin
            if (kill) l = 0;
            else begin
                l = l - 1;
                if (l == 1) r = pend;
                if (l == 0) d = 1'b1;
            end
        end else if (start && !kill) begin
            pend = ref_result(op, a, b);
            l    = ref_latency(op, a, b);
        end
        left      <= l;
        m_done    <= d;
        m_result  <= r;
        m_pending <= pend;
        m_busy    <= (l != 0);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            check("result", 64'(result), 64'(m_result));
        end
    end

    task automatic launch(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = f; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_res, input int unsigned exp_lat);
        int unsigned edges;
        launch(f, x, y);
        edges = 0;
        while (done !== 1'b1 && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        check({name, "_latency"}, 64'(edges), 64'(exp_lat));
        check({name, "_result"}, 64'(result), 64'(exp_res));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || m_busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            $display("FAIL idle_timeout: got busy=%0b expected 0 within 100 cycles", busy);
        end
        @(negedge clk);
    endtask

    initial begin
        int done_cnt;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        reset  = 1'b0;
        cmp_en = 1'b1;

        run_op("mul",    OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulh",   OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT);
        run_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("div",    OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DIV_LAT);
        run_op("rem",    OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DIV_LAT);
        run_op("divu",   OP_DIVU,   32'd100,        32'd7,         32'd14,        DIV_LAT);

        // kill sampled at CALC cycle 10
        launch(OP_MUL, 32'd7, 32'hFFFF_FFFD);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy", 64'(busy), 64'd0);
        check("kill_result", 64'(result), 64'd14);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check("kill_no_done", 64'(done_cnt), 64'd0);

        // kill and start together in IDLE: start dropped
        @(negedge clk);
        start = 1'b1; kill = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("kill_wins_busy", 64'(busy), 64'd0);

        run_op("divu_by0", OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 2);
        run_op("remu_by0", OP_REMU, 32'd5,         32'd0,         32'd5,         2);
        run_op("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_op("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2);

        // start while in DONE is ignored
        launch(OP_DIVU, 32'd5, 32'd0);
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", 64'(done), 64'd1);
        check("done_result", 64'(result), 64'hFFFF_FFFF);
        @(negedge clk);
        check("start_in_done_ignored", 64'(busy), 64'd0);

        // reset mid-CALC
        launch(OP_DIVU, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_mid_busy", 64'(busy), 64'd0);
        check("reset_mid_result", 64'(result), 64'd0);
        check("reset_mid_done", 64'(done), 64'd0);
        wait_idle();

        for (int i = 0; i < 80; i++) begin
            logic [2:0]  rf;
            logic [31:0] ra, rb;
            int unsigned sel, kc;
            bit          do_kill;
            rf  = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = '0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 15));
            else if (sel == 3) ra = 32'($urandom_range(0, 100));
            do_kill = ($urandom_range(0, 4) == 0);
            kc      = $urandom_range(0, 35);
            launch(rf, ra, rb);
            if (do_kill) begin
                repeat (kc) @(negedge clk);
                kill = 1'b1;
                @(negedge clk);
                kill = 1'b0;
            end
            wait_idle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
